// File: rtl/ipsxe_floating_point_group_carry_serial_v1_0.sv
// Group-serial mantissa adder: adds MAN_WIDTH+1-bit operands GROUP_WIDTH bits per clock, valid/ready on both sides.
// Optional subtract (A-B via inverted B and carry-in 1) when IPSXE_FLOATING_POINT_GROUP_SUB_EN is defined.
module ipsxe_floating_point_group_carry_serial_v1_0 #(
  parameter int MAN_WIDTH   = 52,
  parameter int GROUP_WIDTH = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [MAN_WIDTH:0] i_a,
  input  logic [MAN_WIDTH:0] i_b,
  input  logic               i_sub,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [MAN_WIDTH:0] o_sum,
  output logic               o_cout
);

  localparam int W    = MAN_WIDTH + 1;
  localparam int NGRP = (W + GROUP_WIDTH - 1) / GROUP_WIDTH;
  localparam int PW   = NGRP * GROUP_WIDTH;
  localparam int IW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NGRP - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        a_q, b_q, res_q;
  logic                 carry_q;
  logic [IW-1:0]        idx_q;

  logic [W-1:0]         b_in;
  logic                 cin;
  logic                 accept, last_step;
  logic [GROUP_WIDTH:0] grp_sum;
  logic [PW+GROUP_WIDTH-1:0] res_cat;
  logic [PW-1:0]        res_next;
  logic [PW:0]          res_ext;

`ifdef IPSXE_FLOATING_POINT_GROUP_SUB_EN
  assign b_in = i_sub ? ~i_b : i_b;
  assign cin  = i_sub;
`else
  logic unused_sub;
  assign unused_sub = i_sub;
  assign b_in       = i_b;
  assign cin        = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && i_valid;
  assign last_step = (state_q == RUN) && (idx_q == LAST_IDX);

  // Operands shift right one group per step, so group k always sits in the low bits.
  assign grp_sum  = {1'b0, a_q[GROUP_WIDTH-1:0]} + {1'b0, b_q[GROUP_WIDTH-1:0]}
                  + {{GROUP_WIDTH{1'b0}}, carry_q};
  assign res_cat  = {grp_sum[GROUP_WIDTH-1:0], res_q};
  assign res_next = res_cat[PW+GROUP_WIDTH-1:GROUP_WIDTH];
  // Bit W is a padding bit of the sum when padding exists, otherwise the final carry.
  assign res_ext  = {grp_sum[GROUP_WIDTH], res_next};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_valid = (state_q == DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= PW'(i_a);
      b_q     <= PW'(b_in);
      res_q   <= '0;
      carry_q <= cin;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> GROUP_WIDTH;
      b_q     <= b_q >> GROUP_WIDTH;
      res_q   <= res_next;
      carry_q <= grp_sum[GROUP_WIDTH];
      idx_q   <= idx_q + IW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sum  <= '0;
      o_cout <= 1'b0;
    end else if (last_step) begin
      o_sum  <= res_next[W-1:0];
      o_cout <= res_ext[W];
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_group_carry_serial_v1_0.sv
// Bench for the group-serial adder: vector table, hand sequences, random ops against an arithmetic model.
module tb_ipsxe_floating_point_group_carry_serial_v1_0;

  localparam int W = 53;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, i_sub, i_ready;
  logic [W-1:0] i_a, i_b;
  logic         o_ready, o_valid, o_cout;
  logic [W-1:0] o_sum;

  int n_chk  = 0;
  int n_fail = 0;

  ipsxe_floating_point_group_carry_serial_v1_0 #(.MAN_WIDTH(52), .GROUP_WIDTH(9)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(o_valid),
    .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [W-1:0] a, b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] s, output logic c);
    logic [63:0] t;
`ifdef IPSXE_FLOATING_POINT_GROUP_SUB_EN
    t = 64'(a) + 64'(sub ? ~b : b) + 64'(sub);
`else
    t = 64'(a) + 64'(b);
`endif
    s = t[W-1:0];
    c = t[W];
  endfunction

  // Drive at a falling edge; the next rising edge accepts. Returns the result after the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] s, output logic c);
    int lat;
    chk("ready_before_accept", 64'(o_ready), 64'd1);
    i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency_edges", 64'(lat), 64'd6);
    s = o_sum;
    c = o_cout;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("ready_after_handshake", 64'(o_ready), 64'd1);
    chk("valid_after_handshake", 64'(o_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0] s, es, a, b, held;
    logic         c, ec, sb;

    vecs[0] = '{"full_ripple", ALL1, 53'd1, 1'b0, 53'd0, 1'b1};
    vecs[1] = '{"plain_add", 53'h1234, 53'h0DCC, 1'b0, 53'h2000, 1'b0};
    vecs[2] = '{"zero_add", 53'd0, 53'd0, 1'b0, 53'd0, 1'b0};
    vecs[3] = '{"max_add", ALL1, ALL1, 1'b0, 53'h1F_FFFF_FFFF_FFFE, 1'b1};
`ifdef IPSXE_FLOATING_POINT_GROUP_SUB_EN
    vecs[4] = '{"sub_borrow", 53'h10, 53'h11, 1'b1, ALL1, 1'b0};
    vecs[5] = '{"sub_noborrow", 53'h11, 53'h10, 1'b1, 53'd1, 1'b1};
    vecs[6] = '{"sub_equal", 53'h123456789, 53'h123456789, 1'b1, 53'd0, 1'b1};
`else
    vecs[4] = '{"sub_ignored_a", 53'h10, 53'h11, 1'b1, 53'h21, 1'b0};
    vecs[5] = '{"sub_ignored_b", 53'h11, 53'h10, 1'b1, 53'h21, 1'b0};
    vecs[6] = '{"sub_ignored_c", 53'h123456789, 53'h123456789, 1'b1, 53'h2468ACF12, 1'b0};
`endif

    rst = 1'b1; i_valid = 1'b0; i_sub = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_sum", 64'(o_sum), 64'd0);
    chk("reset_cout", 64'(o_cout), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, s, c);
      chk({vecs[i].name, "_sum"}, 64'(s), 64'(vecs[i].sum));
      chk({vecs[i].name, "_cout"}, 64'(c), 64'(vecs[i].cout));
    end

    // Backpressure, busy-ignore and hold-during-RUN.
    held = o_sum;
    i_a = 53'h1234; i_b = 53'h0DCC; i_sub = 1'b0; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    chk("hold_sum_in_run", 64'(o_sum), 64'(held));
    chk("busy_ready", 64'(o_ready), 64'd0);
    i_a = ALL1; i_b = ALL1; i_sub = 1'b1; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_sub = 1'b0;
    for (int k = 0; k < 20 && !o_valid; k++) @(negedge clk);
    chk("bp_valid", 64'(o_valid), 64'd1);
    chk("bp_sum", 64'(o_sum), 64'h2000);
    chk("bp_cout", 64'(o_cout), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_sum", 64'(o_sum), 64'h2000);
      chk("bp_hold_cout", 64'(o_cout), 64'd0);
      chk("bp_hold_ready", 64'(o_ready), 64'd0);
      chk("bp_hold_valid", 64'(o_valid), 64'd1);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("bp_release_ready", 64'(o_ready), 64'd1);
    chk("bp_release_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    chk("idle_hold_sum", 64'(o_sum), 64'h2000);
    chk("idle_no_reaccept", 64'(o_valid), 64'd0);

    // Reset in the middle of RUN aborts the operation.
    i_a = 53'h999; i_b = 53'h111; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_ready", 64'(o_ready), 64'd1);
    chk("abort_sum", 64'(o_sum), 64'd0);
    rst = 1'b0;
    run_op(53'd5, 53'd7, 1'b0, s, c);
    chk("post_reset_sum", 64'(s), 64'd12);
    chk("post_reset_cout", 64'(c), 64'd0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      a  = W'({$urandom, $urandom});
      b  = W'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) a = ALL1;
      if ($urandom_range(0, 7) == 0) b = a;
      sb = 1'($urandom_range(0, 1));
      model(a, b, sb, es, ec);
      run_op(a, b, sb, s, c);
      chk("rand_sum", 64'(s), 64'(es));
      chk("rand_cout", 64'(c), 64'(ec));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
